// File: rtl/n2r_row_packer_pkg.sv
// Shared types and derived-size helpers for the row packer.
package n2r_row_packer_pkg;

   // FSM encoding for the packer control path.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PACK = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of input beats that make up one full row.
   function automatic int calc_beats_per_row(input int col, input int beat_elems);
      return col / beat_elems;
   endfunction

   // Beat counter width; kept at least one bit so a one-beat row still has a counter.
   function automatic int calc_beat_cnt_w(input int beats_per_row);
      return (beats_per_row > 1) ? $clog2(beats_per_row) : 1;
   endfunction

   // Row counter width, wide enough to hold the full row total.
   function automatic int calc_row_cnt_w(input int row);
      return $clog2(row + 1);
   endfunction

endpackage

// File: rtl/n2r_row_packer.sv
// Packs a narrow valid/ready element stream into full rows, one m_valid pulse
// per completed row, and stops after ROW rows until started again.
module n2r_row_packer
   import n2r_row_packer_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int COL        = 256,
   parameter int ROW        = 2754,
   parameter int BEAT_ELEMS = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [WIDTH*BEAT_ELEMS-1:0]       s_data,
   input  logic                              s_last,
   output logic                              m_valid,
   output logic [WIDTH*COL-1:0]              m_row,
   output logic [$clog2(ROW+1)-1:0]          row_count,
   output logic                              done,
   output logic                              err
);

   localparam int BEATS_PER_ROW = calc_beats_per_row(COL, BEAT_ELEMS);
   localparam int BEAT_CNT_W    = calc_beat_cnt_w(BEATS_PER_ROW);
   localparam int ROW_CNT_W     = calc_row_cnt_w(ROW);
   localparam int ROW_W         = WIDTH * COL;
   localparam int BEAT_W        = WIDTH * BEAT_ELEMS;

   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_ROW - 1);
   localparam logic [ROW_CNT_W-1:0]  LAST_ROW  = ROW_CNT_W'(ROW - 1);

   // A row must be an exact number of beats.
   if (COL % BEAT_ELEMS != 0) begin : g_col_check
      $error("n2r_row_packer: COL must be a multiple of BEAT_ELEMS");
   end

   state_t                  state_q;
   state_t                  state_d;
   logic [BEAT_CNT_W-1:0]   beat_cnt;
   logic [ROW_W-1:0]        pack_q;
   logic [ROW_W-1:0]        row_merged;
   logic                    accept;
   logic                    clear;
   logic                    row_end;
   logic                    final_row;

   assign row_end   = (beat_cnt == LAST_BEAT);
   assign final_row = (row_count == LAST_ROW);

   // Next-state, handshake and counter-clear decode.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      s_ready = 1'b0;
      accept  = 1'b0;
      clear   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_PACK;
               clear   = 1'b1;
            end
         end
         ST_PACK: begin
            s_ready = 1'b1;
            accept  = s_valid;
            if (s_valid && row_end && final_row) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_d = ST_PACK;
               clear   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pack register with the incoming beat dropped into its slot (element 0 in MSBs).
   always_comb begin
      row_merged = pack_q;
      for (int b = 0; b < BEATS_PER_ROW; b++) begin
         if (beat_cnt == BEAT_CNT_W'(b)) begin
            row_merged[ROW_W-1-b*BEAT_W -: BEAT_W] = s_data;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath: beat slotting, row hand-off, counters and protocol checking.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the wide pack/output registers are reset too, so a row cut short by reset never leaks stale data.
         beat_cnt  <= '0;
         pack_q    <= '0;
         m_row     <= '0;
         m_valid   <= 1'b0;
         row_count <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         m_valid <= 1'b0;
         done    <= 1'b0;
         if (clear) begin
            beat_cnt  <= '0;
            row_count <= '0;
            err       <= 1'b0;
         end
         if (accept) begin
            pack_q <= row_merged;
            if (row_end) begin
               beat_cnt  <= '0;
               m_row     <= row_merged;
               m_valid   <= 1'b1;
               row_count <= row_count + ROW_CNT_W'(1);
               done      <= final_row;
            end else begin
               beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            end
            if (s_last != (row_end && final_row)) begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/n2r_row_packer.md
Name: n2r_row_packer

Overview:
- Upstream neighbour of the normal-to-ready buffer.
- Takes a narrow row-major element stream (BEAT_ELEMS elements per beat, valid/ready handshake) and packs it into full WIDTH*COL rows.
- Presents each completed row for one cycle with m_valid, which drives the buffer's fill enable and row input.
- Counts ROW rows per matrix, then signals completion and stalls the stream until restarted.

Parameters:
- WIDTH, 16, bits per fixed-point element.
- COL, 256, elements per row; must be a multiple of BEAT_ELEMS.
- ROW, 2754, rows per matrix.
- BEAT_ELEMS, 4, elements per input beat.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse to begin a matrix.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  WIDTH*BEAT_ELEMS  beat; element 0 in MSBs.
- s_last  in  1  marks the final beat of the matrix.
- m_valid  out  1  one-cycle pulse: m_row holds a new complete row.
- m_row  out  WIDTH*COL  packed row; element 0 in MSBs.
- row_count  out  $clog2(ROW+1)  rows emitted in the current matrix.
- done  out  1  one-cycle pulse after row ROW-1 is emitted.
- err  out  1  sticky s_last protocol error.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: state=IDLE, s_ready=0, m_valid=0, m_row=0, row_count=0, done=0, err=0, beat counter=0, pack register=0.
- FSM states: IDLE, PACK, DONE.
  - IDLE: start goes to PACK next cycle; beat counter, row_count and err clear.
  - PACK: s_ready=1. start is ignored.
  - DONE: s_ready=0. start returns to PACK with counters cleared; otherwise the FSM holds.
- Beat packing:
  - Beat index b (0..COL/BEAT_ELEMS-1) writes s_data into pack register bits [WIDTH*COL-1-b*WIDTH*BEAT_ELEMS -: WIDTH*BEAT_ELEMS].
  - The beat counter increments on each accepted beat and wraps to 0 after the last beat of a row.
- Row emission:
  - On the accepted last beat of a row, m_row <= pack register with the current beat merged in, and m_valid=1 on the following cycle.
  - Latency from that beat to m_valid is 1 cycle.
  - m_row holds its value until the next row completes. This output register double-buffers, so streaming continues at 1 beat/cycle with no bubble.
  - row_count increments in the same cycle m_valid rises.
- Matrix end:
  - When the emitted row is row ROW-1, done pulses together with that m_valid.
  - The FSM enters DONE in the same cycle, so s_ready drops and no further beat is accepted.
- s_last checking:
  - Expected on the last beat of row ROW-1.
  - Asserted on any other accepted beat, or absent on that final beat: err<=1.
  - err is sticky until rst or an accepted start. Data flow is unaffected.
- Backpressure: s_valid=0 in PACK leaves all state unchanged. There is no m-side backpressure; the consumer must take a row every m_valid.
- Minimum input spacing: COL/BEAT_ELEMS>=1 guarantees m_valid pulses are at least 1 cycle apart. When COL==BEAT_ELEMS, m_valid may stay high on consecutive cycles, one row each.
- Reset mid-row: the partial row is discarded and m_valid is not asserted.
- Simultaneous events:
  - start with a beat in IDLE/DONE: the beat is not accepted (s_ready=0).
  - rst with anything: rst wins.

Decomposition:
- Shared package:
  - state encodings (ST_IDLE=2'd0, ST_PACK=2'd1, ST_DONE=2'd2);
  - derived constants BEATS_PER_ROW=COL/BEAT_ELEMS, BEAT_CNT_W=$clog2(BEATS_PER_ROW), ROW_CNT_W=$clog2(ROW+1).
- No sub-module is needed. The packing slot write and output register live in one module.
- A build-time check rejects COL % BEAT_ELEMS != 0.

Test Plan (WIDTH=16, COL=8, ROW=4, BEAT_ELEMS=2 unless noted):
- Basic packing: rst, start, then 16 continuous beats with elements 0x0000..0x001F, s_last on beat 15 -> m_valid on cycles after beats 3/7/11/15.
  - Row0 = 0x0000_0001_0002_..._0007 (MSB first).
  - row_count 1..4; done with the 4th m_valid; s_ready=0 afterwards; err=0.
- Backpressure: random s_valid gaps during the same 16 beats -> identical m_row values, each m_valid exactly 1 cycle after the row's 4th accepted beat.
- Protocol error: s_last on beat 5 -> err=1 from the next cycle. Rows are still emitted correctly. err clears on the next accepted start.
- Restart from DONE: after done, start, then 16 new beats -> row_count restarts at 1 and four rows are emitted. Beats offered while in DONE before start are not accepted.
- Reset mid-row: rst after 2 beats of row 2 -> all outputs at reset values, no m_valid. After start, row 0 is built from fresh beats only.
- COL=BEAT_ELEMS=2, ROW=3: 3 continuous beats -> m_valid high 3 consecutive cycles, done on the third, row_count=3.
